// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared memory geometry defaults and block-copier state encoding
package mem_defs;

  localparam int MEM_DATA_WIDTH = 12;
  localparam int MEM_DEPTH      = 256;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    WR   = ST_WR,
    DONE = ST_DONE
  } copy_state_t;

endpackage

// File: rtl/ram_block_copier.sv
// rtl/ram_block_copier.sv - copies a block of RAM words upward, one read then one write per word
module ram_block_copier
  import mem_defs::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_wrEn,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_dataIn,
  input  logic [DATA_WIDTH-1:0] ram_dataOut
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_SUM = (ADDR_WIDTH+2)'(DEPTH);

  copy_state_t             state, state_next;
  logic [ADDR_WIDTH-1:0]   src_q, dst_q;
  logic [ADDR_WIDTH:0]     len_q, idx_q;
  logic [ADDR_WIDTH:0]     len_clamped, idx_inc;

  // Address arithmetic wraps modulo DEPTH, which need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [ADDR_WIDTH:0]   offset);
    logic [ADDR_WIDTH+1:0] sum;
    sum = {2'b00, base} + {1'b0, offset};
    if (sum >= DEPTH_SUM) sum = sum - DEPTH_SUM;
    return sum[ADDR_WIDTH-1:0];
  endfunction

  assign len_clamped = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign idx_inc     = idx_q + (ADDR_WIDTH+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start && length != '0) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len_clamped;
        idx_q <= '0;
      end else if (state == WR) begin
        idx_q <= idx_inc;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (length == '0) ? DONE : RD;
      RD:   state_next = WR;
      WR:   state_next = (idx_inc < len_q) ? RD : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A reset arriving during a write cycle suppresses that write immediately.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    ram_wrEn    = 1'b0;
    ram_address = '0;
    ram_dataIn  = '0;
    case (state)
      RD: ram_address = wrap_add(src_q, idx_q);
      WR: begin
        ram_address = wrap_add(dst_q, idx_q);
        ram_wrEn    = ~rst;
        ram_dataIn  = ram_dataOut;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_block_copier.sv
// tb/tb_ram_block_copier.sv - bench for ram_block_copier with a registered-read RAM beside it
module tb_ram_block_copier;

  typedef struct {
    logic        busy;
    logic        done;
    logic        we;
    logic [7:0]  addr;
    logic [11:0] data;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, ram_wrEn;
  logic [7:0]  src_addr, dst_addr, ram_address;
  logic [8:0]  length;
  logic [11:0] ram_dataIn, ram_dataOut;
  logic        init, ld_en;
  logic [7:0]  ld_addr;
  logic [11:0] ld_data;
  logic        chk_on;

  logic [11:0] mem     [256];
  logic [11:0] ref_mem [256];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ram_block_copier #(.DATA_WIDTH(12), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .ram_wrEn(ram_wrEn),
    .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  function automatic logic [11:0] pat(input int k);
    return 12'(k * 5 + 1);
  endfunction

  // registered-address RAM
  always @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < 256; k++) mem[k] <= pat(k);
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (ram_wrEn) begin
      mem[ram_address] <= ram_dataIn;
    end
    ram_dataOut <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cycle_outputs",
            {41'd0, busy, done, ram_wrEn, ram_address, e.chk_data ? ram_dataIn : 12'h0},
            {41'd0, e.busy, e.done, e.we, e.addr, e.chk_data ? e.data : 12'h0});
      end else begin
        chk("idle_outputs", {41'd0, busy, done, ram_wrEn, ram_address, ram_dataIn}, 64'd0);
      end
    end
  end

  task automatic load_word(input int a, input logic [11:0] v);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 8'(a); ld_data = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic check_mem(input string name);
    int diffs;
    diffs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) diffs++;
    chk(name, 64'(diffs), 64'd0);
  endtask

  // mode 0: plain copy; 1: re-poke start/src while busy; 2: reset during cycle 4
  task automatic run_copy(input int s, input int d, input int l, input int mode,
                          output int done_cyc, output int busy_cnt,
                          output int we_cnt, output int done_cnt);
    int          n;
    logic [11:0] scratch [256];
    done_cyc = 0; busy_cnt = 0; we_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 8'(s); dst_addr = 8'(d); length = 9'(l);
    @(posedge clk); #1;
    start = 1'b0; src_addr = 8'($urandom); dst_addr = 8'($urandom); length = 9'($urandom);
    n = (l > 256) ? 256 : l;
    scratch = ref_mem;
    for (int k = 0; k < n; k++) begin
      int a, b;
      a = (s + k) % 256;
      b = (d + k) % 256;
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'(a), 12'h0, 1'b0});
      exp_q.push_back('{1'b1, 1'b0, 1'b1, 8'(b), scratch[a], 1'b1});
      scratch[b] = scratch[a];
    end
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 8'h0, 12'h0, 1'b1});
    for (int c = 1; c <= 1200; c++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      we_cnt   += int'(ram_wrEn);
      done_cnt += int'(done);
      if (done && done_cyc == 0) done_cyc = c;
      if (mode == 1 && c == 2) begin start = 1'b1; src_addr = 8'd99; end
      if (mode == 1 && c == 5) start = 1'b0;
      if (mode == 2 && c == 3) begin
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        e = exp_q.pop_front();
        e.we = 1'b0;
        exp_q.delete();
        exp_q.push_back(e);
        ref_mem[d % 256] = ref_mem[s % 256];
      end
      if (mode == 2 && c == 4) break;
      if (mode != 2 && done_cyc != 0) break;
    end
    if (mode == 2) begin
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      if (done_cyc == 0) chk("copy_timeout", 64'd0, 64'd1);
      ref_mem = scratch;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, bc, wc, nc;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    init = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; chk_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0; rst = 1'b0;
    for (int k = 0; k < 256; k++) ref_mem[k] = pat(k);
    @(negedge clk);
    chk("reset_outputs", {41'd0, busy, done, ram_wrEn, ram_address, ram_dataIn}, 64'd0);
    chk_on = 1'b1;

    load_word(10, 12'h111); load_word(11, 12'h222);
    load_word(12, 12'h333); load_word(13, 12'h444);
    run_copy(10, 100, 4, 0, dc, bc, wc, nc);
    chk("basic_done_cycle", 64'(dc), 64'd9);
    chk("basic_busy_cycles", 64'(bc), 64'd9);
    chk("basic_dst_words", {16'd0, mem[100], mem[101], mem[102], mem[103]},
        {16'd0, 12'h111, 12'h222, 12'h333, 12'h444});
    check_mem("basic_mem_image");

    run_copy(5, 7, 0, 0, dc, bc, wc, nc);
    chk("zero_len_done_cycle", 64'(dc), 64'd1);
    chk("zero_len_writes", 64'(wc), 64'd0);
    check_mem("zero_len_mem_image");

    run_copy(254, 0, 4, 0, dc, bc, wc, nc);
    chk("wrap_dst_words", {16'd0, mem[0], mem[1], mem[2], mem[3]},
        {16'd0, 12'h4F7, 12'h4FC, 12'h4F7, 12'h4FC});
    check_mem("wrap_mem_image");

    run_copy(20, 40, 3, 1, dc, bc, wc, nc);
    chk("busy_restart_done_cycle", 64'(dc), 64'd7);
    chk("busy_restart_done_count", 64'(nc), 64'd1);
    check_mem("busy_restart_mem_image");

    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; src_addr = 8'd1; dst_addr = 8'd2; length = 9'd5;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_beats_start_busy", 64'(busy), 64'd0);
    check_mem("reset_beats_start_mem_image");

    run_copy(50, 150, 8, 2, dc, bc, wc, nc);
    chk("abort_word0", 64'(mem[150]), 64'h0FB);
    chk("abort_word1_untouched", 64'(mem[151]), 64'h2F4);
    chk("abort_done_count", 64'(nc), 64'd0);
    chk("abort_write_count", 64'(wc), 64'd1);
    repeat (2) @(negedge clk);
    check_mem("abort_mem_image");

    run_copy(0, 0, 256, 0, dc, bc, wc, nc);
    chk("full_done_cycle", 64'(dc), 64'd513);
    chk("full_write_count", 64'(wc), 64'd256);
    check_mem("full_mem_image");

    run_copy(3, 3, 400, 0, dc, bc, wc, nc);
    chk("clamp_done_cycle", 64'(dc), 64'd513);
    check_mem("clamp_mem_image");

    repeat (3) @(negedge clk);
    chk("trailing_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
